// File: rtl/seven_segment_scanner_if.sv
// seven_segment_scanner_if: display content in, scanned segment/digit out.
// master drives content, slave is the scanner.
interface seven_segment_scanner_if #(
  parameter int w_digit = 8
);
  logic [4*w_digit-1:0] number;
  logic [w_digit-1:0]   dots;
  logic                 lzb;
  logic [7:0]           abcdefgh;
  logic [w_digit-1:0]   digit;
  logic                 frame_done;

  modport master (
    output number, dots, lzb,
    input  abcdefgh, digit, frame_done
  );

  modport slave (
    input  number, dots, lzb,
    output abcdefgh, digit, frame_done
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: time-multiplexed 7-seg driver.
// Per-frame snapshot, gap-blanked slots, leading-zero blanking.
module seven_segment_scanner #(
  parameter int clk_mhz    = 50,
  parameter int w_digit    = 8,
  parameter int refresh_hz = 100,
  parameter int gap_cycles = 4
) (
  input  logic clk,
  input  logic rst,
  seven_segment_scanner_if.slave io
);
  localparam int DC =
    clk_mhz * 1_000_000 / (w_digit * refresh_hz);
  localparam int CW = (DC > 1) ? $clog2(DC) : 1;
  localparam int IW = (w_digit > 1) ? $clog2(w_digit) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DC - 1);
  localparam logic [CW-1:0] GAP     = CW'(gap_cycles);
  localparam logic [IW-1:0] IDX_MAX = IW'(w_digit - 1);

  if (DC < 2 || gap_cycles >= DC) begin : g_bad_params
    $error("seven_segment_scanner: bad digit_cycles/gap_cycles");
  end

  logic [CW-1:0]        cnt, cnt_nxt;
  logic [IW-1:0]        idx, idx_nxt;
  logic                 wrap, snap;
  logic [4*w_digit-1:0] sh_num;
  logic [w_digit-1:0]   sh_dots;
  logic                 sh_lzb;
  logic [3:0]           nib;
  logic                 lead_zero, blank, show;
  logic [7:0]           seg_nxt;
  logic [w_digit-1:0]   digit_nxt;
  logic                 fd_nxt;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h00;
    unique case (v)
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h7B;
      4'hA: s = 7'h77;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      4'hF: s = 7'h47;
    endcase
    return s;
  endfunction

  // slot counter and digit index, plus frame snapshot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      idx     <= '0;
      sh_num  <= '0;
      sh_dots <= '0;
      sh_lzb  <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      idx <= idx_nxt;
      if (snap) begin
        sh_num  <= io.number;
        sh_dots <= io.dots;
        sh_lzb  <= io.lzb;
      end
    end
  end

  // advance cnt every cycle, idx on cnt wrap
  always_comb begin
    wrap    = (cnt == CNT_MAX);
    snap    = (cnt == '0) && (idx == '0);
    cnt_nxt = wrap ? '0 : cnt + CW'(1);
    idx_nxt = idx;
    if (wrap)
      idx_nxt = (idx == IDX_MAX) ? '0 : idx + IW'(1);
  end

  // next outputs from the current slot phase and shadow copy
  always_comb begin
    nib       = sh_num[4*idx +: 4];
    lead_zero = 1'b1;
    for (int j = 0; j < w_digit; j++) begin
      if (j >= int'(idx) && sh_num[4*j +: 4] != 4'h0)
        lead_zero = 1'b0;
    end
    blank     = sh_lzb && (idx != '0) && lead_zero;
    show      = (cnt >= GAP);
    digit_nxt = '0;
    seg_nxt   = 8'h00;
    if (show) begin
      digit_nxt = w_digit'(1) << idx;
      seg_nxt   = {blank ? 7'h00 : seg7(nib), sh_dots[idx]};
    end
    fd_nxt = wrap && (idx == IDX_MAX);
  end

  // registered outputs, one cycle behind the counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      io.abcdefgh   <= 8'h00;
      io.digit      <= '0;
      io.frame_done <= 1'b0;
    end else begin
      io.abcdefgh   <= seg_nxt;
      io.digit      <= digit_nxt;
      io.frame_done <= fd_nxt;
    end
  end
endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: directed + random frames
// against a frame-arithmetic reference model.
module tb_seven_segment_scanner;
  localparam int WD    = 8;
  localparam int DC    = 10;
  localparam int GAP   = 2;
  localparam int FRAME = WD * DC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vec = 0;
  int   errs = 0;
  int   n = 0;

  logic [31:0] m_num;
  logic [7:0]  m_dots;
  logic        m_lzb;

  logic [7:0] tbl [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  seven_segment_scanner_if #(.w_digit(WD)) bus ();

  seven_segment_scanner #(
    .clk_mhz(1), .w_digit(WD),
    .refresh_hz(12500), .gap_cycles(GAP)
  ) dut (
    .clk(clk), .rst(rst), .io(bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h want %h (t=%0t)",
             tag, obs, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".digit"}, 32'(bus.digit), 32'h0);
    chk({tag, ".seg"}, 32'(bus.abcdefgh), 32'h0);
    chk({tag, ".fd"}, 32'(bus.frame_done), 32'h0);
  endtask

  task automatic step();
    int s, slot, c;
    logic [7:0] ed, es;
    logic efd, blank;
    logic [31:0] upper;
    @(posedge clk);
    n++;
    s = (n - 1) % FRAME;
    if (s == 0) begin
      m_num  = bus.number;
      m_dots = bus.dots;
      m_lzb  = bus.lzb;
    end
    #1;
    slot = s / DC;
    c    = s % DC;
    ed   = 8'h00;
    es   = 8'h00;
    if (c >= GAP) begin
      upper = m_num >> (4 * slot);
      blank = m_lzb && slot > 0 && upper == 0;
      ed    = 8'(1) << slot;
      es    = (blank ? 8'h00 : tbl[upper[3:0]])
              | {7'h0, m_dots[slot]};
    end
    efd = (s == FRAME - 1);
    chk("digit", 32'(bus.digit), 32'(ed));
    chk("seg", 32'(bus.abcdefgh), 32'(es));
    chk("frame_done", 32'(bus.frame_done), 32'(efd));
    chk("onehot", 32'($countones(bus.digit) <= 1), 32'h1);
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk_zero("rst_async");
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_zero("rst_hold");
    end
    @(negedge clk);
    rst = 1'b1;
    n = 0;
  endtask

  initial begin
    bus.number = 32'h0123_4567;
    bus.dots   = 8'h00;
    bus.lzb    = 1'b0;
    #3;
    chk_zero("reset");
    do_reset();
    run(FRAME);

    bus.lzb    = 1'b1;
    bus.number = 32'h0000_00A5;
    run(FRAME);
    bus.number = 32'h0;
    run(FRAME);

    bus.lzb    = 1'b0;
    bus.dots   = 8'h04;
    bus.number = 32'h8888_8888;
    run(FRAME);
    bus.lzb    = 1'b1;
    bus.number = 32'h0;
    run(FRAME);

    bus.lzb    = 1'b0;
    bus.dots   = 8'h00;
    bus.number = 32'h1234_5678;
    run(30);
    bus.number = 32'h9ABC_DEF0;
    bus.dots   = 8'hFF;
    run(FRAME - 30);
    run(FRAME);

    run(55);
    #1;
    rst = 1'b0;
    #1;
    chk_zero("rst_mid");
    do_reset();
    run(FRAME);

    bus.dots   = 8'h00;
    bus.number = 32'hFEDC_BA98;
    run(FRAME);
    bus.number = 32'h7654_3210;
    run(FRAME);

    for (int f = 0; f < 12; f++) begin
      int k;
      bus.number = $urandom;
      if ($urandom_range(0, 1) == 1)
        bus.number = bus.number >> (4 * $urandom_range(1, 8));
      bus.dots = 8'($urandom);
      bus.lzb  = 1'($urandom);
      k = $urandom_range(1, FRAME - 1);
      run(k);
      bus.number = $urandom;
      bus.lzb    = 1'($urandom);
      run(FRAME - k);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end
endmodule
